// File: rtl/alu_issue_stage.sv
// ID/EX stage for the 32-bit MIPS ALU. It registers the ID operands and control, decodes ALUOp/funct into the ALU op code,
// applies EX/MEM and MEM/WB forwarding to the ALU inputs, and raises a stall on a load-use hazard.
module alu_issue_stage #(
    parameter int W  = 32,
    parameter int RA = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [W-1:0]  id_rs_data,
    input  logic [W-1:0]  id_rt_data,
    input  logic [W-1:0]  id_imm,
    input  logic [RA-1:0] id_rs,
    input  logic [RA-1:0] id_rt,
    input  logic [RA-1:0] id_rd,
    input  logic          id_alu_src,
    input  logic [1:0]    id_alu_op,
    input  logic [5:0]    id_funct,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_branch,
    input  logic          flush,
    input  logic          exmem_reg_write,
    input  logic [RA-1:0] exmem_rd,
    input  logic [W-1:0]  exmem_data,
    input  logic          memwb_reg_write,
    input  logic [RA-1:0] memwb_rd,
    input  logic [W-1:0]  memwb_data,
    output logic          stall,
    output logic          ex_valid,
    output logic [3:0]    ex_op,
    output logic [W-1:0]  ex_a,
    output logic [W-1:0]  ex_b,
    output logic [W-1:0]  ex_store_data,
    output logic [RA-1:0] ex_dest,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_branch,
    output logic          ex_illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic          valid_q,     valid_d;
    logic [3:0]    op_q,        op_d;
    logic          illegal_q,   illegal_d;
    logic [RA-1:0] rs_q,        rs_d;
    logic [RA-1:0] rt_q,        rt_d;
    logic [W-1:0]  rs_data_q,   rs_data_d;
    logic [W-1:0]  rt_data_q,   rt_data_d;
    logic [W-1:0]  imm_q,       imm_d;
    logic          alu_src_q,   alu_src_d;
    logic [RA-1:0] dest_q,      dest_d;
    logic          reg_write_q, reg_write_d;
    logic          mem_read_q,  mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          branch_q,    branch_d;

    logic [3:0]    dec_op;
    logic          dec_illegal;
    logic          load_bubble;
    logic          hazard_rs;
    logic          hazard_rt;
    logic [W-1:0]  fwd_a;
    logic [W-1:0]  fwd_b;

    always_comb begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
        unique case (id_alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b11: dec_op = OP_OR;
            default: begin
                unique case (id_funct)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b100111: dec_op = OP_NOR;
                    6'b101010: dec_op = OP_SLT;
                    default: begin
                        dec_op      = OP_ADD;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // rt only counts as a source when it feeds the ALU b input or is the store data.
    always_comb begin
        hazard_rs = (dest_q == id_rs);
        hazard_rt = (dest_q == id_rt) && (!id_alu_src || id_mem_write);
        stall     = id_valid && valid_q && mem_read_q && (dest_q != '0) && (hazard_rs || hazard_rt);
    end

    assign load_bubble = flush || stall || !id_valid;

    always_comb begin
        rs_d        = id_rs;
        rt_d        = id_rt;
        rs_data_d   = id_rs_data;
        rt_data_d   = id_rt_data;
        imm_d       = id_imm;
        alu_src_d   = id_alu_src;
        op_d        = dec_op;
        dest_d      = id_reg_dst ? id_rd : id_rt;
        valid_d     = 1'b1;
        illegal_d   = dec_illegal;
        reg_write_d = id_reg_write && !dec_illegal;
        mem_read_d  = id_mem_read;
        mem_write_d = id_mem_write;
        branch_d    = id_branch;
        if (load_bubble) begin
            valid_d     = 1'b0;
            illegal_d   = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            branch_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            op_q        <= '0;
            illegal_q   <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            dest_q      <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            op_q        <= op_d;
            illegal_q   <= illegal_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            alu_src_q   <= alu_src_d;
            dest_q      <= dest_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            branch_q    <= branch_d;
        end
    end

    // The younger producer (EX/MEM) wins; register 0 is hardwired and never forwarded.
    always_comb begin
        fwd_a = rs_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q)) begin
            fwd_a = exmem_data;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q)) begin
            fwd_a = memwb_data;
        end
    end

    always_comb begin
        fwd_b = rt_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q)) begin
            fwd_b = exmem_data;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q)) begin
            fwd_b = memwb_data;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_op         = op_q;
    assign ex_a          = fwd_a;
    assign ex_b          = alu_src_q ? imm_q : fwd_b;
    assign ex_store_data = fwd_b;
    assign ex_dest       = dest_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_branch     = branch_q;
    assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: an instruction-level model of the EX slot is compared every cycle,
// and hand-computed literals pin the model at the interesting points.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_alu_src;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_data;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        stall, ex_valid;
    logic [3:0]  ex_op;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;

    alu_issue_stage #(.W(32), .RA(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .stall(stall), .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_illegal(ex_illegal)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model of the instruction occupying EX, described in ISA terms.
    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic        illegal;
        logic [4:0]  rs, rt, dest;
        logic [31:0] rs_data, rt_data, imm;
        logic        use_imm, reg_write, mem_read, mem_write, branch;
    } ex_t;

    ex_t m = '0;
    logic m_stall;

    function automatic logic [4:0] alu_code(input logic [1:0] aop, input logic [5:0] f);
        if (aop == 2'b00) return 5'h02;
        if (aop == 2'b01) return 5'h06;
        if (aop == 2'b11) return 5'h01;
        case (f)
            6'h20:   return 5'h02;
            6'h22:   return 5'h06;
            6'h24:   return 5'h00;
            6'h25:   return 5'h01;
            6'h27:   return 5'h0C;
            6'h2A:   return 5'h07;
            default: return 5'h12;
        endcase
    endfunction

    function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] from_id);
        if (r == 5'd0) return from_id;
        if (exmem_reg_write && exmem_rd == r) return exmem_data;
        if (memwb_reg_write && memwb_rd == r) return memwb_data;
        return from_id;
    endfunction

    always_comb begin
        m_stall = 1'b0;
        if (id_valid && m.valid && m.mem_read && m.dest != 5'd0)
            if (m.dest == id_rs || (m.dest == id_rt && (!id_alu_src || id_mem_write)))
                m_stall = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
        end else if (flush || m_stall || !id_valid) begin
            m <= '0;
        end else begin
            m <= '{valid: 1'b1, op: alu_code(id_alu_op, id_funct) & 5'h0F,
                   illegal: alu_code(id_alu_op, id_funct) >= 5'h10,
                   rs: id_rs, rt: id_rt, dest: id_reg_dst ? id_rd : id_rt,
                   rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
                   use_imm: id_alu_src,
                   reg_write: id_reg_write && (alu_code(id_alu_op, id_funct) < 5'h10),
                   mem_read: id_mem_read, mem_write: id_mem_write, branch: id_branch};
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("stall", 32'(stall), 32'(m_stall));
            check("ex_valid", 32'(ex_valid), 32'(m.valid));
            check("ex_reg_write", 32'(ex_reg_write), 32'(m.reg_write));
            check("ex_mem_read", 32'(ex_mem_read), 32'(m.mem_read));
            check("ex_mem_write", 32'(ex_mem_write), 32'(m.mem_write));
            check("ex_branch", 32'(ex_branch), 32'(m.branch));
            if (m.valid) begin
                check("ex_op", 32'(ex_op), 32'(m.op));
                check("ex_illegal", 32'(ex_illegal), 32'(m.illegal));
                check("ex_dest", 32'(ex_dest), 32'(m.dest));
                check("ex_a", ex_a, reg_value(m.rs, m.rs_data));
                check("ex_b", ex_b, m.use_imm ? m.imm : reg_value(m.rt, m.rt_data));
                check("ex_store_data", ex_store_data, reg_value(m.rt, m.rt_data));
            end
        end
    end

    task automatic clear_id();
        id_valid = 1'b0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_alu_src = 1'b0; id_alu_op = 2'b00;
        id_funct = '0; id_reg_dst = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_mem_write = 1'b0; id_branch = 1'b0;
    endtask

    task automatic rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
        clear_id();
        id_valid = 1'b1; id_rd = rd; id_rs = rs; id_rt = rt; id_rs_data = a; id_rt_data = b;
        id_alu_op = 2'b10; id_funct = f; id_reg_dst = 1'b1; id_reg_write = 1'b1;
    endtask

    task automatic lw(input logic [4:0] rt, input logic [4:0] rs, input logic [31:0] base, input logic [31:0] off);
        clear_id();
        id_valid = 1'b1; id_rt = rt; id_rs = rs; id_rs_data = base; id_imm = off;
        id_alu_src = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("txn t=%0t ex_valid=%0d op=%0h a=%0h b=%0h dest=%0d stall=%0d",
                 $time, ex_valid, ex_op, ex_a, ex_b, ex_dest, stall);
    endtask

    logic [1:0] t_aop [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00};
    logic [5:0] t_fn  [10] = '{6'h24, 6'h25, 6'h27, 6'h2A, 6'h22, 6'h20, 6'h08, 6'h00, 6'h3F, 6'h08};
    int         t_op  [10] = '{0, 1, 12, 7, 6, 2, 2, 6, 1, 2};
    int         t_ill [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        clear_id();
        flush = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_data = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_data = '0;
        repeat (2) step();
        check("reset_valid", 32'(ex_valid), 0);
        check("reset_stall", 32'(stall), 0);
        check("reset_op", 32'(ex_op), 0);
        rst_n = 1'b1;

        // add $3,$1,$2 with $1=5, $2=7
        rtype(5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 6'h20);
        step();
        check("first_valid", 32'(ex_valid), 1);
        check("first_op", 32'(ex_op), 2);
        check("first_a", ex_a, 5);
        check("first_b", ex_b, 7);
        check("first_dest", 32'(ex_dest), 3);
        check("first_reg_write", 32'(ex_reg_write), 1);

        // lw $8 in EX, add $9,$8,$2 in ID, then reset lands in the middle of the stall
        lw(5'd8, 5'd1, 32'd5, 32'd0);
        step();
        check("lw_mem_read", 32'(ex_mem_read), 1);
        rtype(5'd9, 5'd8, 5'd2, 32'd0, 32'd3, 6'h20);
        #1 check("pre_reset_stall", 32'(stall), 1);
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(ex_valid), 0);
        check("async_stall", 32'(stall), 0);
        check("async_mem_read", 32'(ex_mem_read), 0);
        check("async_a", ex_a, 0);
        check("async_store", ex_store_data, 0);
        check("async_dest", 32'(ex_dest), 0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            rtype(5'd10, 5'd1, 5'd2, 32'd11, 32'd22, t_fn[i]);
            id_alu_op = t_aop[i];
            step();
            check("sweep_op", 32'(ex_op), t_op[i]);
            check("sweep_illegal", 32'(ex_illegal), t_ill[i]);
            check("sweep_reg_write", 32'(ex_reg_write), 32'(t_ill[i] == 0));
        end

        // forwarding priority on rs=4, then rt=5 from MEM/WB
        rtype(5'd6, 5'd4, 5'd5, 32'd1, 32'd2, 6'h20);
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_data = 32'hAA;
        memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_data = 32'hBB;
        #1 check("fwd_exmem_wins", ex_a, 32'hAA);
        exmem_reg_write = 1'b0;
        #1 check("fwd_memwb", ex_a, 32'hBB);
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1 check("fwd_r0_none", ex_a, 32'd1);
        memwb_rd = 5'd5; memwb_data = 32'hCC;
        #1 check("fwd_b_memwb", ex_b, 32'hCC);
        check("fwd_store_memwb", ex_store_data, 32'hCC);
        #1;
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0; memwb_rd = 5'd0;

        // load-use: lw $8 then add $9,$8,$2
        lw(5'd8, 5'd1, 32'd100, 32'd4);
        step();
        rtype(5'd9, 5'd8, 5'd2, 32'd0, 32'd3, 6'h20);
        #1 check("lu_stall", 32'(stall), 1);
        step();
        check("lu_bubble", 32'(ex_valid), 0);
        check("lu_bubble_rw", 32'(ex_reg_write), 0);
        check("lu_stall_drop", 32'(stall), 0);
        step();
        memwb_reg_write = 1'b1; memwb_rd = 5'd8; memwb_data = 32'h1234;
        #1;
        check("lu_issue_valid", 32'(ex_valid), 1);
        check("lu_issue_a", ex_a, 32'h1234);
        check("lu_issue_b", ex_b, 32'd3);
        memwb_reg_write = 1'b0; memwb_rd = 5'd0;

        // immediate consumer does not stall; store of the loaded register does
        lw(5'd8, 5'd1, 32'd100, 32'd4);
        step();
        clear_id();
        id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd8; id_alu_src = 1'b1; id_imm = 32'h10; id_reg_write = 1'b1;
        #1 check("addi_no_stall", 32'(stall), 0);
        id_reg_write = 1'b0; id_mem_write = 1'b1;
        #1 check("sw_stall", 32'(stall), 1);

        // flush together with the hazard
        flush = 1'b1;
        #1 check("flush_stall_out", 32'(stall), 1);
        step();
        check("flush_bubble", 32'(ex_valid), 0);
        check("flush_mem_write", 32'(ex_mem_write), 0);
        flush = 1'b0;
        rtype(5'd5, 5'd1, 5'd2, 32'd9, 32'd4, 6'h22);
        step();
        check("after_flush_valid", 32'(ex_valid), 1);
        check("after_flush_dest", 32'(ex_dest), 5);
        check("after_flush_sub", 32'(ex_op), 6);

        // flush alone, then an invalid ID slot, then a branch
        flush = 1'b1;
        step();
        check("flush_only", 32'(ex_valid), 0);
        flush = 1'b0;
        id_valid = 1'b0;
        step();
        check("id_invalid", 32'(ex_valid), 0);
        clear_id();
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rs_data = 32'd3; id_rt_data = 32'd3;
        id_alu_op = 2'b01; id_branch = 1'b1;
        step();
        check("beq_branch", 32'(ex_branch), 1);
        check("beq_op", 32'(ex_op), 6);
        clear_id();
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
